y86_regfile_wb: RTL and testbench

Parametrised register file for the SEQ processor that merges decode-stage operand read with write-back. It decodes source and destination registers from `icode`, `rA` and `rB` itself, and holds the architectural register state. It registers `valA`/`valB` for the execute stage. It commits `valE`/`valM` with Y86 write-port priority, conditional-move gating and optional same-cycle bypass.

---
 rtl/y86_regfile_wb.sv | 156 +++++++++++++++
 tb/tb_y86_regfile_wb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/y86_regfile_wb.sv
// Y86 SEQ register file: decodes source/destination registers, registers
// operands A/B for execute and commits valE/valM with cmov gating and optional bypass.
module y86_regfile_wb #(
   parameter int               WIDTH    = 64,
   parameter int               NREGS    = 15,
   parameter logic [WIDTH-1:0] RSP_INIT = '0,
   parameter bit               BYPASS   = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dec_valid,
   input  logic [3:0]       icode,
   input  logic [3:0]       rA,
   input  logic [3:0]       rB,
   input  logic             wb_valid,
   input  logic [3:0]       wb_icode,
   input  logic [3:0]       wb_rA,
   input  logic [3:0]       wb_rB,
   input  logic             wb_cnd,
   input  logic [WIDTH-1:0] valE,
   input  logic [WIDTH-1:0] valM,
   output logic             out_valid,
   output logic [WIDTH-1:0] valA,
   output logic [WIDTH-1:0] valB
);

   localparam logic [3:0] RNONE   = 4'hF;
   localparam logic [3:0] RSP     = 4'h4;
   localparam logic [3:0] NREGS_L = 4'(NREGS);

   function automatic logic [3:0] dec_src_a(input logic [3:0] ic, input logic [3:0] ra);
      case (ic)
         4'h2, 4'h4, 4'h6, 4'hA: return ra;
         4'h9, 4'hB:             return RSP;
         default:                return RNONE;
      endcase
   endfunction

   function automatic logic [3:0] dec_src_b(input logic [3:0] ic, input logic [3:0] rb);
      case (ic)
         4'h4, 4'h5, 4'h6:       return rb;
         4'h8, 4'h9, 4'hA, 4'hB: return RSP;
         default:                return RNONE;
      endcase
   endfunction

   function automatic logic [3:0] dec_dst_e(input logic [3:0] ic, input logic [3:0] rb,
                                            input logic cnd);
      case (ic)
         4'h2:                   return cnd ? rb : RNONE;
         4'h3, 4'h6:             return rb;
         4'h8, 4'h9, 4'hA, 4'hB: return RSP;
         default:                return RNONE;
      endcase
   endfunction

   function automatic logic [3:0] dec_dst_m(input logic [3:0] ic, input logic [3:0] ra);
      case (ic)
         4'h5, 4'hB: return ra;
         default:    return RNONE;
      endcase
   endfunction

   // valM beats valE on a shared target; out-of-range indices read as zero
   function automatic logic [WIDTH-1:0] rd_val(input logic [3:0]       idx,
                                                input logic [WIDTH-1:0] stored,
                                                input logic             we,
                                                input logic [3:0]       de,
                                                input logic [3:0]       dm,
                                                input logic [WIDTH-1:0] ve,
                                                input logic [WIDTH-1:0] vm);
      logic [WIDTH-1:0] r;
      if (idx >= NREGS_L) begin
         r = '0;
      end else if (BYPASS && we && (dm == idx)) begin
         r = vm;
      end else if (BYPASS && we && (de == idx)) begin
         r = ve;
      end else begin
         r = stored;
      end
      return r;
   endfunction

   logic [WIDTH-1:0] regs_q [16];
   logic [WIDTH-1:0] regs_d [16];
   logic [WIDTH-1:0] val_a_q, val_a_d;
   logic [WIDTH-1:0] val_b_q, val_b_d;
   logic             out_valid_q;
   logic [3:0]       src_a_s, src_b_s, dst_e_s, dst_m_s;
   logic [WIDTH-1:0] rd_a_s, rd_b_s;

   // Register decode for both the read and write-back sides
   always_comb begin
      src_a_s = dec_src_a(icode, rA);
      src_b_s = dec_src_b(icode, rB);
      dst_e_s = dec_dst_e(wb_icode, wb_rB, wb_cnd);
      dst_m_s = dec_dst_m(wb_icode, wb_rA);
   end

   // Write-back next state: the M port is applied last so it wins a conflict
   always_comb begin
      regs_d = regs_q;
      if (wb_valid) begin
         if (dst_e_s < NREGS_L) begin
            regs_d[dst_e_s] = valE;
         end else begin
            regs_d[dst_e_s] = regs_q[dst_e_s];
         end
         if (dst_m_s < NREGS_L) begin
            regs_d[dst_m_s] = valM;
         end else begin
            regs_d[dst_m_s] = regs_q[dst_m_s];
         end
      end else begin
         regs_d = regs_q;
      end
   end

   // Operand read and hold of valA/valB when no decode is requested
   always_comb begin
      rd_a_s = rd_val(src_a_s, regs_q[src_a_s], wb_valid, dst_e_s, dst_m_s, valE, valM);
      rd_b_s = rd_val(src_b_s, regs_q[src_b_s], wb_valid, dst_e_s, dst_m_s, valE, valM);
      if (dec_valid) begin
         val_a_d = rd_a_s;
         val_b_d = rd_b_s;
      end else begin
         val_a_d = val_a_q;
         val_b_d = val_b_q;
      end
   end

   // State update; entries at or above NREGS are tied to zero
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            regs_q[i] <= (i == 4) ? RSP_INIT : '0;
         end
         val_a_q     <= '0;
         val_b_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < 16; i++) begin
            regs_q[i] <= (i < NREGS) ? regs_d[i] : '0;
         end
         val_a_q     <= val_a_d;
         val_b_q     <= val_b_d;
         out_valid_q <= dec_valid;
      end
   end

   assign out_valid = out_valid_q;
   assign valA      = val_a_q;
   assign valB      = val_b_q;

endmodule

// File: tb/tb_y86_regfile_wb.sv
// Bench for y86_regfile_wb: three builds (bypass, no bypass, 8 registers) share
// stimulus and are compared against an array-based architectural model.
module tb_y86_regfile_wb;

   localparam logic [63:0] RSP0 = 64'h100;

   logic        clk = 1'b0;
   logic        rst, dec_valid, wb_valid, wb_cnd;
   logic [3:0]  icode, rA, rB, wb_icode, wb_rA, wb_rB;
   logic [63:0] valE, valM;
   logic        ov [3];
   logic [63:0] va [3];
   logic [63:0] vb [3];

   int n_checks = 0;
   int n_errors = 0;

   // model state
   logic [63:0] mreg [3][16];
   logic        e_ov;
   logic [63:0] e_a [3];
   logic [63:0] e_b [3];
   int          nr [3] = '{15, 15, 8};
   bit          bp [3] = '{1'b1, 1'b0, 1'b1};

   always #5 clk = ~clk;

   y86_regfile_wb #(.WIDTH(64), .NREGS(15), .RSP_INIT(RSP0), .BYPASS(1'b1)) u_byp (
      .clk(clk), .rst(rst), .dec_valid(dec_valid), .icode(icode), .rA(rA), .rB(rB),
      .wb_valid(wb_valid), .wb_icode(wb_icode), .wb_rA(wb_rA), .wb_rB(wb_rB),
      .wb_cnd(wb_cnd), .valE(valE), .valM(valM),
      .out_valid(ov[0]), .valA(va[0]), .valB(vb[0]));

   y86_regfile_wb #(.WIDTH(64), .NREGS(15), .RSP_INIT(RSP0), .BYPASS(1'b0)) u_nobyp (
      .clk(clk), .rst(rst), .dec_valid(dec_valid), .icode(icode), .rA(rA), .rB(rB),
      .wb_valid(wb_valid), .wb_icode(wb_icode), .wb_rA(wb_rA), .wb_rB(wb_rB),
      .wb_cnd(wb_cnd), .valE(valE), .valM(valM),
      .out_valid(ov[1]), .valA(va[1]), .valB(vb[1]));

   y86_regfile_wb #(.WIDTH(64), .NREGS(8), .RSP_INIT(RSP0), .BYPASS(1'b1)) u_small (
      .clk(clk), .rst(rst), .dec_valid(dec_valid), .icode(icode), .rA(rA), .rB(rB),
      .wb_valid(wb_valid), .wb_icode(wb_icode), .wb_rA(wb_rA), .wb_rB(wb_rB),
      .wb_cnd(wb_cnd), .valE(valE), .valM(valM),
      .out_valid(ov[2]), .valA(va[2]), .valB(vb[2]));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] m_srca(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
      if (ic inside {4'h9, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] m_srcb(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] m_dste(input logic [3:0] ic, input logic [3:0] rb,
                                         input logic c);
      if (ic == 4'h2) return c ? rb : 4'hF;
      if (ic inside {4'h3, 4'h6}) return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] m_dstm(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h5, 4'hB}) return ra;
      return 4'hF;
   endfunction

   // Apply one clock edge to the model: compute post-write state, then read
   task automatic model_edge();
      logic [63:0] nw [16];
      logic [3:0]  de, dm, sa, sb;
      de = m_dste(wb_icode, wb_rB, wb_cnd);
      dm = m_dstm(wb_icode, wb_rA);
      sa = m_srca(icode, rA);
      sb = m_srcb(icode, rB);
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            for (int i = 0; i < 16; i++) mreg[k][i] = (i == 4) ? RSP0 : 64'd0;
            e_a[k] = 64'd0;
            e_b[k] = 64'd0;
         end else begin
            for (int i = 0; i < 16; i++) nw[i] = mreg[k][i];
            if (wb_valid && int'(de) < nr[k]) nw[de] = valE;
            if (wb_valid && int'(dm) < nr[k]) nw[dm] = valM;
            if (dec_valid) begin
               e_a[k] = (int'(sa) >= nr[k]) ? 64'd0 : (bp[k] ? nw[sa] : mreg[k][sa]);
               e_b[k] = (int'(sb) >= nr[k]) ? 64'd0 : (bp[k] ? nw[sb] : mreg[k][sb]);
            end
            for (int i = 0; i < 16; i++) mreg[k][i] = nw[i];
         end
      end
      e_ov = rst ? 1'b0 : dec_valid;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("ov%0d", k), {63'd0, ov[k]}, {63'd0, e_ov});
         check($sformatf("valA%0d", k), va[k], e_a[k]);
         check($sformatf("valB%0d", k), vb[k], e_b[k]);
      end
   endtask

   task automatic set_dec(input logic dv, input logic [3:0] ic, input logic [3:0] ra,
                          input logic [3:0] rb);
      dec_valid = dv; icode = ic; rA = ra; rB = rb;
   endtask

   task automatic set_wb(input logic wv, input logic [3:0] ic, input logic [3:0] ra,
                         input logic [3:0] rb, input logic c, input logic [63:0] ve,
                         input logic [63:0] vm);
      wb_valid = wv; wb_icode = ic; wb_rA = ra; wb_rB = rb; wb_cnd = c; valE = ve; valM = vm;
   endtask

   initial begin
      rst = 1'b1;
      set_dec(1'b0, 4'h0, 4'hF, 4'hF);
      set_wb(1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
      cyc();
      // write-back concurrent with reset must be lost
      set_wb(1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'hAB, 64'd0);
      cyc();
      rst = 1'b0;
      set_wb(1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
      set_dec(1'b1, 4'hA, 4'h3, 4'hF);
      cyc();
      check("rst_ov", {63'd0, ov[0]}, 64'd1);
      check("rst_pushA", va[0], 64'd0);
      check("rst_pushB", vb[0], 64'h100);
      set_dec(1'b1, 4'h6, 4'h2, 4'hF);
      cyc();
      check("rst_wlost", va[0], 64'd0);
      // irmovq then read
      set_dec(1'b0, 4'h0, 4'hF, 4'hF);
      set_wb(1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'd0);
      cyc();
      check("hold_ov", {63'd0, ov[0]}, 64'd0);
      set_wb(1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
      set_dec(1'b1, 4'h6, 4'h2, 4'hF);
      cyc();
      check("irmov_A", va[0], 64'h1234);
      check("irmov_B", vb[0], 64'd0);
      // popq %rsp conflict
      set_dec(1'b0, 4'h0, 4'hF, 4'hF);
      set_wb(1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hDEAD);
      cyc();
      set_wb(1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
      set_dec(1'b1, 4'h9, 4'hF, 4'hF);
      cyc();
      check("popsp_A", va[0], 64'hDEAD);
      check("popsp_B", vb[0], 64'hDEAD);
      // cmov gating
      set_dec(1'b0, 4'h0, 4'hF, 4'hF);
      set_wb(1'b1, 4'h2, 4'hF, 4'h5, 1'b0, 64'd7, 64'd0);
      cyc();
      set_wb(1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
      set_dec(1'b1, 4'h2, 4'h5, 4'hF);
      cyc();
      check("cmov_n", va[0], 64'd0);
      set_dec(1'b0, 4'h0, 4'hF, 4'hF);
      set_wb(1'b1, 4'h2, 4'hF, 4'h5, 1'b1, 64'd7, 64'd0);
      cyc();
      set_wb(1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
      set_dec(1'b1, 4'h2, 4'h5, 4'hF);
      cyc();
      check("cmov_y", va[0], 64'd7);
      // bypass vs no bypass
      set_dec(1'b0, 4'h0, 4'hF, 4'hF);
      set_wb(1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'h11, 64'd0);
      cyc();
      set_wb(1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'h55, 64'd0);
      set_dec(1'b1, 4'h2, 4'h1, 4'hF);
      cyc();
      check("byp1", va[0], 64'h55);
      check("byp0", va[1], 64'h11);
      set_wb(1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
      cyc();
      check("byp1_nxt", va[0], 64'h55);
      check("byp0_nxt", va[1], 64'h55);
      // out-of-range destination on the 8-register build
      set_dec(1'b0, 4'h0, 4'hF, 4'hF);
      set_wb(1'b1, 4'h3, 4'hF, 4'h9, 1'b0, 64'hFF, 64'd0);
      cyc();
      set_wb(1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
      set_dec(1'b1, 4'h6, 4'h9, 4'h1);
      cyc();
      check("n8_oorA", va[2], 64'd0);
      check("n8_r1", vb[2], 64'h55);
      check("n15_r9", va[0], 64'hFF);
      // randomized traffic
      for (int t = 0; t < 1500; t++) begin
         rst = ($urandom_range(0, 60) == 0);
         set_dec(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         set_wb(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
         cyc();
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
